piso_serializer: RTL and testbench

- Parallel-in serial-out framer that sits directly upstream of the SIPO shift register.
- Accepts WIDTH-bit words through a valid/ready handshake and drives them out one bit per clock on a serial line.
- Its serial output is what the SIPO stage's serial data input consumes.
- A one-word holding buffer allows back-to-back frames with no idle cycle between them.

---
 rtl/piso_serializer.sv | 114 +++++++++++
 tb/tb_piso_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer: accepts WIDTH-bit words over valid/ready and
// emits them one bit per clock, with a one-word holding buffer so consecutive
// frames stream without an idle cycle.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic             accept;
  logic             valid_n;
  logic             bit_n;
  logic [WIDTH-1:0] shifted;

  // Handshake qualifier and one-position advance of the shift register
  always_comb begin
    accept  = load_valid & load_ready;
    shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  end

  // Next-state logic: frame sequencing, buffer fill/drain and boundary bypass
  always_comb begin
    state_n     = state;
    count_n     = count;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_n = load_data;
          count_n = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          // Buffered word has priority; load_ready is low so no accept collides
          if (hold_full) begin
            shreg_n     = hold;
            hold_full_n = 1'b0;
            count_n     = '0;
          end else if (accept) begin
            shreg_n = load_data;
            count_n = '0;
          end else begin
            shreg_n = '0;
            count_n = '0;
            state_n = IDLE;
          end
        end else begin
          shreg_n = shifted;
          count_n = count + CW'(1);
          if (accept) begin
            hold_n      = load_data;
            hold_full_n = 1'b1;
          end
        end
      end
    endcase
    valid_n = (state_n == SHIFT);
    bit_n   = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];
  end

  // State and registered outputs, derived from the next-state values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      shreg       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      load_ready  <= 1'b1;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      shreg       <= shreg_n;
      hold        <= hold_n;
      hold_full   <= hold_full_n;
      load_ready  <= ~hold_full_n;
      sout        <= valid_n & bit_n;
      sout_valid  <= valid_n;
      frame_start <= valid_n & (count_n == '0);
      frame_done  <= valid_n & (count_n == LAST);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// on a shared clock/reset, with a behavioural SIPO on the LSB-first line.
module tb_piso_serializer;

  logic       clk;
  logic       rst;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_sout;
  logic       m_sout_valid;
  logic       m_start;
  logic       m_done;

  logic [7:0] l_data;
  logic       l_valid;
  logic       l_ready;
  logic       l_sout;
  logic       l_sout_valid;
  logic       l_start;
  logic       l_done;

  logic [7:0] sipo;

  int tests;
  int fails;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .rst         (rst),
    .load_data   (m_data),
    .load_valid  (m_valid),
    .load_ready  (m_ready),
    .sout        (m_sout),
    .sout_valid  (m_sout_valid),
    .frame_start (m_start),
    .frame_done  (m_done)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .rst         (rst),
    .load_data   (l_data),
    .load_valid  (l_valid),
    .load_ready  (l_ready),
    .sout        (l_sout),
    .sout_valid  (l_sout_valid),
    .frame_start (l_start),
    .frame_done  (l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream SIPO model: LSB-first capture of valid serial bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sipo <= '0;
    else if (l_sout_valid) sipo <= {l_sout, sipo[7:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one MSB-first bit position i of word w on the MSB instance
  task automatic check_mbit(input string tag, input logic [7:0] w, input int i);
    check($sformatf("%s sout[%0d]", tag, i), 32'(m_sout), 32'(w[7-i]));
    check($sformatf("%s valid[%0d]", tag, i), 32'(m_sout_valid), 32'd1);
    check($sformatf("%s start[%0d]", tag, i), 32'(m_start), 32'(i == 0));
    check($sformatf("%s done[%0d]", tag, i), 32'(m_done), 32'(i == 7));
  endtask

  task automatic check_midle(input string tag);
    check({tag, " idle valid"}, 32'(m_sout_valid), 32'd0);
    check({tag, " idle sout"}, 32'(m_sout), 32'd0);
    check({tag, " idle ready"}, 32'(m_ready), 32'd1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    m_valid = 1'b1;
    m_data  = 8'hA5;
    l_valid = 1'b1;
    l_data  = 8'h96;

    // Reset held with valid asserted and clock running
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst sout", 32'(m_sout), 32'd0);
      check("rst valid", 32'(m_sout_valid), 32'd0);
      check("rst ready", 32'(m_ready), 32'd1);
      check("rst lsb valid", 32'(l_sout_valid), 32'd0);
    end
    m_valid = 1'b0;
    l_valid = 1'b0;
    rst     = 1'b1;
    tick();
    check_midle("post-rst");

    // Single frame A5, MSB first
    m_valid = 1'b1;
    m_data  = 8'hA5;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_mbit("single", 8'hA5, i);
      tick();
    end
    check_midle("single");

    // Back-to-back A5 then 3C via the holding buffer
    m_valid = 1'b1;
    m_data  = 8'hA5;
    tick();
    m_data  = 8'h3C;
    check_mbit("b2b A5", 8'hA5, 0);
    check("b2b ready0", 32'(m_ready), 32'd1);
    tick();
    m_data  = 8'hEE;
    for (int i = 1; i < 8; i++) begin
      check_mbit("b2b A5", 8'hA5, i);
      check($sformatf("b2b ready[%0d]", i), 32'(m_ready), 32'd0);
      tick();
    end
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_mbit("b2b 3C", 8'h3C, i);
      check($sformatf("b2b3C ready[%0d]", i), 32'(m_ready), 32'd1);
      tick();
    end
    check_midle("b2b");

    // Boundary bypass: 0F presented on the last bit of F0
    m_valid = 1'b1;
    m_data  = 8'hF0;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_mbit("byp F0", 8'hF0, i);
      check($sformatf("bypF0 ready[%0d]", i), 32'(m_ready), 32'd1);
      if (i == 7) begin
        m_valid = 1'b1;
        m_data  = 8'h0F;
      end
      tick();
      m_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      check_mbit("byp 0F", 8'h0F, i);
      check($sformatf("byp0F ready[%0d]", i), 32'(m_ready), 32'd1);
      tick();
    end
    check_midle("byp");

    // LSB first into the SIPO model
    l_valid = 1'b1;
    l_data  = 8'h96;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h96;
      check($sformatf("lsb sout[%0d]", i), 32'(l_sout), 32'(w[i]));
      check($sformatf("lsb valid[%0d]", i), 32'(l_sout_valid), 32'd1);
      check($sformatf("lsb start[%0d]", i), 32'(l_start), 32'(i == 0));
      check($sformatf("lsb done[%0d]", i), 32'(l_done), 32'(i == 7));
      tick();
    end
    check("lsb sipo byte", 32'(sipo), 32'h96);
    check("lsb idle valid", 32'(l_sout_valid), 32'd0);

    // Reset mid-frame with a word held
    m_valid = 1'b1;
    m_data  = 8'hFF;
    tick();
    m_data  = 8'h11;
    check_mbit("mrst FF", 8'hFF, 0);
    tick();
    m_valid = 1'b0;
    check_mbit("mrst FF", 8'hFF, 1);
    check("mrst held ready", 32'(m_ready), 32'd0);
    tick();
    check_mbit("mrst FF", 8'hFF, 2);
    #3;
    rst = 1'b0;
    #1;
    check("mrst async valid", 32'(m_sout_valid), 32'd0);
    check("mrst async sout", 32'(m_sout), 32'd0);
    check("mrst async start", 32'(m_start), 32'd0);
    check("mrst async done", 32'(m_done), 32'd0);
    check("mrst async ready", 32'(m_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_midle("mrst release");
    m_valid = 1'b1;
    m_data  = 8'h81;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_mbit("mrst 81", 8'h81, i);
      tick();
    end
    check_midle("mrst 81");
    tick();
    check_midle("mrst final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
